// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and key-code helpers for the keypad responder.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        B_IN  = 3'd1,
        HOLD  = 3'd2,
        B_OUT = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [3:0] c_ROW_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

    // Legend value reported by the scanner; '*' maps to 4'hE, '#' to 4'hF.
    function automatic logic [3:0] key_value(input logic [3:0] key);
        logic [3:0] v;
        case (key)
            4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
            4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
            4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
            4'hC: v = 4'hE;  4'hD: v = 4'h0;  4'hE: v = 4'hF;  default: v = 4'hD;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_row_drive.sv
`default_nettype none
// ============================================================================
// Module      : keypad_row_drive
// Description : Combinational contact/column to active-low row mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_row_drive
    import keypad_pkg::*;
(
    input  logic       i_contact,
    input  logic [3:0] i_key,
    input  logic [3:0] i_col,
    output logic [3:0] o_row
);

    logic [1:0] w_key_r;
    logic       w_col_sel;

    assign w_key_r   = key_row(i_key);
    assign w_col_sel = ~i_col[key_col(i_key)];

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign o_row[r] = ~(i_contact && w_col_sel && (w_key_r == 2'(r)));
    end

endmodule
`default_nettype wire

// File: rtl/keypad_responder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_responder
// Description : 4x4 matrix keypad emulator with deterministic contact bounce.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int BOUNCE_CYCLES = 8,
    parameter int RELEASE_GAP   = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_key,
    input  logic [CNT_W-1:0] req_hold,
    input  logic             cancel,
    output logic             busy,
    output logic             done
);

    localparam bit              c_HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
    localparam logic [CNT_W-1:0] c_BOUNCE_LAST = CNT_W'(c_HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] c_GAP_LAST    = CNT_W'(RELEASE_GAP - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold_last;
    logic [3:0]       r_key;
    logic             r_contact;
    logic             w_contact_nxt;
    logic             w_cnt_clr;
    logic             w_accept;
    logic             w_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_last <= '0;
            r_key       <= '0;
            r_contact   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_contact <= w_contact_nxt;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (r_state != IDLE)
                r_cnt <= r_cnt + CNT_W'(1);
            // Store hold-1 so a zero hold behaves as one and the max hold never wraps.
            if (w_accept) begin
                r_key       <= req_key;
                r_hold_last <= (req_hold == '0) ? '0 : req_hold - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_contact_nxt = r_contact;
        w_cnt_clr     = 1'b0;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                w_contact_nxt = 1'b0;
                if (req_valid) begin
                    w_accept      = 1'b1;
                    w_cnt_clr     = 1'b1;
                    w_contact_nxt = 1'b1;
                    w_state_nxt   = c_HAS_BOUNCE ? B_IN : HOLD;
                end
            end
            B_IN: begin
                if (cancel) begin
                    w_state_nxt   = GAP;
                    w_contact_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end else if (r_cnt == c_BOUNCE_LAST) begin
                    w_state_nxt   = HOLD;
                    w_contact_nxt = 1'b1;
                    w_cnt_clr     = 1'b1;
                end else begin
                    w_contact_nxt = ~r_contact;
                end
            end
            HOLD: begin
                w_contact_nxt = 1'b1;
                if (cancel) begin
                    w_state_nxt   = GAP;
                    w_contact_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end else if (r_cnt >= r_hold_last) begin
                    w_state_nxt   = c_HAS_BOUNCE ? B_OUT : GAP;
                    w_contact_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end
            end
            B_OUT: begin
                if (cancel || (r_cnt == c_BOUNCE_LAST)) begin
                    w_state_nxt   = GAP;
                    w_contact_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end else begin
                    w_contact_nxt = ~r_contact;
                end
            end
            GAP: begin
                w_contact_nxt = 1'b0;
                if (r_cnt == c_GAP_LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_contact_nxt = 1'b0;
                w_cnt_clr     = 1'b1;
            end
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = w_done;

    keypad_row_drive u_row_drive (
        .i_contact (r_contact),
        .i_key     (r_key),
        .i_col     (col),
        .o_row     (row)
    );

endmodule
`default_nettype wire

// File: tb/tb_keypad_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_responder
// Description : Self-checking bench for keypad_responder (bounce and no-bounce builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_responder;
    import keypad_pkg::*;

    localparam int CNT_W    = 16;
    localparam int BOUNCE_N = 8;
    localparam int GAP_N    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [3:0]       col;

    logic             b8_valid, b8_ready, b8_cancel, b8_busy, b8_done;
    logic [3:0]       b8_key, b8_row;
    logic [CNT_W-1:0] b8_hold;
    logic             b0_valid, b0_ready, b0_cancel, b0_busy, b0_done;
    logic [3:0]       b0_key, b0_row;
    logic [CNT_W-1:0] b0_hold;

    keypad_responder #(.CNT_W(CNT_W), .BOUNCE_CYCLES(BOUNCE_N), .RELEASE_GAP(GAP_N)) u_dut8 (
        .clk(clk), .reset(reset), .col(col), .row(b8_row),
        .req_valid(b8_valid), .req_ready(b8_ready), .req_key(b8_key), .req_hold(b8_hold),
        .cancel(b8_cancel), .busy(b8_busy), .done(b8_done)
    );

    keypad_responder #(.CNT_W(CNT_W), .BOUNCE_CYCLES(0), .RELEASE_GAP(GAP_N)) u_dut0 (
        .clk(clk), .reset(reset), .col(col), .row(b0_row),
        .req_valid(b0_valid), .req_ready(b0_ready), .req_key(b0_key), .req_hold(b0_hold),
        .cancel(b0_cancel), .busy(b0_busy), .done(b0_done)
    );

    typedef struct packed { logic contact; logic done; } exp_t;
    typedef struct { logic [3:0] key; logic [3:0] col; logic [3:0] row; } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] row_of(input bit w);   return w ? b8_row   : b0_row;   endfunction
    function automatic logic       done_of(input bit w);  return w ? b8_done  : b0_done;  endfunction
    function automatic logic       busy_of(input bit w);  return w ? b8_busy  : b0_busy;  endfunction
    function automatic logic       ready_of(input bit w); return w ? b8_ready : b0_ready; endfunction

    task automatic set_req(input bit w, input logic v, input logic [3:0] k, input logic [CNT_W-1:0] h);
        if (w) begin b8_valid = v; b8_key = k; b8_hold = h; end
        else   begin b0_valid = v; b0_key = k; b0_hold = h; end
    endtask

    task automatic set_cancel(input bit w, input logic c);
        if (w) b8_cancel = c; else b0_cancel = c;
    endtask

    // Expected contact level per cycle of one press, first cycle after the accepting edge.
    task automatic push_profile(input int bounce, input int n_hold, input bit with_bout);
        for (int i = 0; i < bounce; i++) sb.push_back('{contact: (i % 2 == 0), done: 1'b0});
        for (int i = 0; i < n_hold; i++) sb.push_back('{contact: 1'b1, done: 1'b0});
        if (with_bout)
            for (int i = 0; i < bounce; i++) sb.push_back('{contact: (i % 2 == 1), done: 1'b0});
        for (int i = 0; i < GAP_N; i++) sb.push_back('{contact: 1'b0, done: (i == GAP_N - 1)});
    endtask

    task automatic run_profile(input bit w, input logic [3:0] key, input int cancel_idx, input string tag);
        exp_t       e;
        int         idx;
        logic [3:0] exp_row;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            set_cancel(w, idx == cancel_idx);
            col = ~(4'b0001 << key_col(key));
            #1;
            exp_row = e.contact ? ~(4'b0001 << key_row(key)) : 4'b1111;
            check({tag, " row"},   row_of(w),   exp_row);
            check({tag, " done"},  done_of(w),  e.done);
            check({tag, " busy"},  busy_of(w),  1'b1);
            check({tag, " ready"}, ready_of(w), 1'b0);
            idx++;
            step;
        end
        set_cancel(w, 1'b0);
        check({tag, " idle busy"},  busy_of(w),  1'b0);
        check({tag, " idle ready"}, ready_of(w), 1'b1);
        check({tag, " idle done"},  done_of(w),  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        bit got;

        vecs[0] = '{4'h6, 4'b1011, 4'b1101};
        vecs[1] = '{4'h6, 4'b1110, 4'b1111};
        vecs[2] = '{4'h6, 4'b0000, 4'b1101};
        vecs[3] = '{4'h6, 4'b1111, 4'b1111};
        vecs[4] = '{4'hF, 4'b0111, 4'b0111};
        vecs[5] = '{4'hC, 4'b1110, 4'b0111};
        vecs[6] = '{4'h3, 4'b0111, 4'b1110};
        vecs[7] = '{4'h9, 4'b1101, 4'b1011};
        vecs[8] = '{4'h9, 4'b1011, 4'b1111};

        reset = 1'b0;
        col   = 4'b1111;
        set_req(1'b0, 1'b0, 4'h0, '0);
        set_req(1'b1, 1'b0, 4'h0, '0);
        set_cancel(1'b0, 1'b0);
        set_cancel(1'b1, 1'b0);
        repeat (3) step;
        reset = 1'b1;
        step;

        col = 4'b1110;
        #1;
        check("reset row b8", b8_row, 4'b1111);
        check("reset row b0", b0_row, 4'b1111);
        check("reset ready",  b8_ready, 1'b1);
        check("reset busy",   b8_busy, 1'b0);
        check("reset done",   b8_done, 1'b0);
        step;

        // No bounce: 5 hold cycles then 16 gap cycles; cancel during GAP must be ignored.
        set_req(1'b0, 1'b1, 4'h6, 16'd5);
        step;
        set_req(1'b0, 1'b0, 4'h0, '0);
        push_profile(0, 5, 1'b0);
        run_profile(1'b0, 4'h6, 10, "nobounce");

        // cancel in IDLE does not block a request.
        set_cancel(1'b0, 1'b1);
        set_req(1'b0, 1'b1, 4'h3, 16'd1);
        step;
        set_req(1'b0, 1'b0, 4'h0, '0);
        push_profile(0, 1, 1'b0);
        run_profile(1'b0, 4'h3, -1, "idlecancel");

        // Row mapping vectors taken in the first HOLD cycle, then cancelled.
        for (int v = 0; v < 9; v++) begin
            set_req(1'b0, 1'b1, vecs[v].key, 16'd4);
            step;
            set_req(1'b0, 1'b0, 4'h0, '0);
            col = vecs[v].col;
            #1;
            check($sformatf("vec%0d row", v), b0_row, vecs[v].row);
            set_cancel(1'b0, 1'b1);
            step;
            set_cancel(1'b0, 1'b0);
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                if (b0_done) got = 1'b1;
                step;
            end
            check($sformatf("vec%0d done seen", v), got, 1'b1);
        end

        // Full bounce profile with req_hold=0.
        set_req(1'b1, 1'b1, 4'h0, 16'd0);
        step;
        set_req(1'b1, 1'b0, 4'h0, '0);
        push_profile(BOUNCE_N, 1, 1'b1);
        run_profile(1'b1, 4'h0, -1, "bounce");

        // Back-to-back: second request waits until the first IDLE cycle after done.
        set_req(1'b1, 1'b1, 4'h5, 16'd2);
        step;
        set_req(1'b1, 1'b1, 4'hA, 16'd3);
        push_profile(BOUNCE_N, 2, 1'b1);
        run_profile(1'b1, 4'h5, -1, "b2b first");
        step;
        set_req(1'b1, 1'b0, 4'h0, '0);
        push_profile(BOUNCE_N, 3, 1'b1);
        run_profile(1'b1, 4'hA, -1, "b2b second");

        // Cancel in the 3rd HOLD cycle of a long hold.
        set_req(1'b1, 1'b1, 4'hD, 16'd100);
        step;
        set_req(1'b1, 1'b0, 4'h0, '0);
        push_profile(BOUNCE_N, 3, 1'b0);
        run_profile(1'b1, 4'hD, BOUNCE_N + 2, "cancel");

        // Asynchronous reset in the middle of HOLD.
        set_req(1'b1, 1'b1, 4'h6, 16'd100);
        step;
        set_req(1'b1, 1'b0, 4'h0, '0);
        col = 4'b1011;
        repeat (9) step;
        check("midreset pre row", b8_row, 4'b1101);
        #1;
        reset = 1'b0;
        #1;
        check("midreset row",   b8_row, 4'b1111);
        check("midreset busy",  b8_busy, 1'b0);
        check("midreset ready", b8_ready, 1'b1);
        step;
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step;
            if (b8_done) done_cnt++;
        end
        check("midreset no done", done_cnt, 0);
        check("midreset ready after", b8_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
